// File: rtl/iir_pkg.sv
// Shared constants for the biquad cascade: coefficient slot indices, default widths
// and the unity-gain b0 used to bring every section up as a passthrough.
package iir_pkg;

  localparam int DEF_N_SECTIONS = 2;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_COEF_W     = 16;
  localparam int DEF_FRAC_BITS  = 14;
  localparam int N_COEF         = 5;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;

  // Unity gain in the coefficient Q format.
  function automatic logic signed [31:0] passthrough_b0(input int frac_bits);
    return 32'sd1 <<< frac_bits;
  endfunction

endpackage

// File: rtl/iir_biquad_section.sv
// One direct-form-I biquad: history, full-precision MAC, floor shift and output register.
// Output clamping and clip reporting are built only when IIR_SAT_EN is defined.
module iir_biquad_section
  import iir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam int ACC_W = DATA_W + COEF_W + 3;

  logic signed [DATA_W-1:0] x1_r, x2_r, y1_r, y2_r;
  logic                     valid_r, sat_r;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [DATA_W-1:0] res_s;
  logic                     clip_s;

`ifdef IIR_SAT_EN
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted_s;
`endif

  // Five-tap MAC at accumulator width, then floor-scale back to sample width.
  always_comb begin
    acc_s = ACC_W'(b0) * ACC_W'(x)    + ACC_W'(b1) * ACC_W'(x1_r) + ACC_W'(b2) * ACC_W'(x2_r)
          - ACC_W'(a1) * ACC_W'(y1_r) - ACC_W'(a2) * ACC_W'(y2_r);
`ifdef IIR_SAT_EN
    shifted_s = acc_s >>> FRAC_BITS;
    if (shifted_s == ACC_W'($signed(shifted_s[DATA_W-1:0]))) begin
      res_s  = shifted_s[DATA_W-1:0];
      clip_s = 1'b0;
    end else if (shifted_s[ACC_W-1]) begin
      res_s  = D_MIN;
      clip_s = 1'b1;
    end else begin
      res_s  = D_MAX;
      clip_s = 1'b1;
    end
`else
    res_s  = DATA_W'(acc_s >>> FRAC_BITS);
    clip_s = 1'b0;
`endif
  end

  // History and output register; history moves only when a sample is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_r    <= {DATA_W{1'b0}};
      x2_r    <= {DATA_W{1'b0}};
      y1_r    <= {DATA_W{1'b0}};
      y2_r    <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (clear) begin
      x1_r    <= {DATA_W{1'b0}};
      x2_r    <= {DATA_W{1'b0}};
      y1_r    <= {DATA_W{1'b0}};
      y2_r    <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (in_valid) begin
      x1_r    <= x;
      x2_r    <= x1_r;
      y1_r    <= res_s;
      y2_r    <= y1_r;
      valid_r <= 1'b1;
      sat_r   <= clip_s;
    end else begin
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign y         = y1_r;
  assign sat       = sat_r;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SECTIONS biquads with a shared coefficient register file and sticky clip flag.
// Define IIR_SAT_EN to build saturating sections; otherwise outputs wrap and sat_flag stays 0.
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int N_SECTIONS = DEF_N_SECTIONS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int COEF_W     = DEF_COEF_W,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic signed [DATA_W-1:0]            x,
  output logic                                out_valid,
  output logic signed [DATA_W-1:0]            y,
  input  logic                                coef_we,
  input  logic [$clog2(N_SECTIONS)+3-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]            coef_data,
  input  logic                                clear,
  output logic                                sat_flag
);

  localparam int ADDR_W = $clog2(N_SECTIONS) + 3;

  logic signed [COEF_W-1:0] coef_r [N_SECTIONS][N_COEF];
  logic [ADDR_W-1:0]        sec_s;
  logic [2:0]               idx_s;
  logic                     write_ok_s;

  logic                     valid_s [N_SECTIONS+1];
  logic signed [DATA_W-1:0] data_s  [N_SECTIONS+1];
  logic [N_SECTIONS-1:0]    sat_vec_s;
  logic                     sat_flag_r;

  // Split the address and drop writes to unused slots or absent sections.
  always_comb begin
    sec_s = coef_addr >> 3;
    idx_s = coef_addr[2:0];
    if (coef_we && (int'(idx_s) < N_COEF) && (int'(sec_s) < N_SECTIONS)) begin
      write_ok_s = 1'b1;
    end else begin
      write_ok_s = 1'b0;
    end
  end

  // Coefficient file; clear leaves it untouched, reset restores passthrough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < N_SECTIONS; s++) begin
        for (int i = 0; i < N_COEF; i++) begin
          coef_r[s][i] <= (i == 0) ? COEF_W'(passthrough_b0(FRAC_BITS)) : {COEF_W{1'b0}};
        end
      end
    end else begin
      for (int s = 0; s < N_SECTIONS; s++) begin
        for (int i = 0; i < N_COEF; i++) begin
          if (write_ok_s && (int'(sec_s) == s) && (int'(idx_s) == i)) begin
            coef_r[s][i] <= coef_data;
          end
        end
      end
    end
  end

  assign valid_s[0] = in_valid;
  assign data_s[0]  = x;

  for (genvar g = 0; g < N_SECTIONS; g++) begin : g_sec
    iir_biquad_section #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_sec (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (valid_s[g]),
      .x         (data_s[g]),
      .b0        (coef_r[g][IDX_B0]),
      .b1        (coef_r[g][IDX_B1]),
      .b2        (coef_r[g][IDX_B2]),
      .a1        (coef_r[g][IDX_A1]),
      .a2        (coef_r[g][IDX_A2]),
      .out_valid (valid_s[g+1]),
      .y         (data_s[g+1]),
      .sat       (sat_vec_s[g])
    );
  end

  // Sticky clip flag, cleared only by reset or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag_r <= 1'b0;
    end else if (clear) begin
      sat_flag_r <= 1'b0;
    end else if (|sat_vec_s) begin
      sat_flag_r <= 1'b1;
    end
  end

  assign out_valid = valid_s[N_SECTIONS];
  assign y         = data_s[N_SECTIONS];
  assign sat_flag  = sat_flag_r;

endmodule

// File: doc/iir_biquad_cascade.md
IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 SHALL have parameters: N_SECTIONS, default 2, number of cascaded biquad sections (1..8).
REQ-002 SHALL have parameters: DATA_W, default 32, signed sample width.
REQ-003 SHALL have parameters: COEF_W, default 16, signed coefficient width.
REQ-004 SHALL have parameters: FRAC_BITS, default 14, coefficient fraction bits (Q format).
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  x carries a sample this cycle.
- x  in  DATA_W  signed input sample.
- out_valid  out  1  y carries a result this cycle.
- y  out  DATA_W  signed output sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(N_SECTIONS)+3  {section, index}; index 0..4 = b0,b1,b2,a1,a2.
- coef_data  in  COEF_W  signed coefficient.
- clear  in  1  synchronous flush of all filter history.
- sat_flag  out  1  sticky: some section clipped since reset or clear.

Function
REQ-006 Each section SHALL compute direct form I: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; out = acc >>> FRAC_BITS (arithmetic shift, floor).
REQ-007 The accumulator SHALL be DATA_W+COEF_W+3 bits; no intermediate overflow permitted.
REQ-008 Each section SHALL register its output; y/out_valid SHALL appear exactly N_SECTIONS cycles after the accepted in_valid.
REQ-009 Section history (x1,x2,y1,y2) SHALL advance only on cycles where that section's input valid is high; bubbles SHALL leave history unchanged.
REQ-010 Back-to-back in_valid every cycle SHALL be sustained with no stall.
REQ-011 A coefficient write SHALL take effect on the cycle after coef_we; a section computing in that write cycle SHALL use the old value.
REQ-012 coef_addr index 5..7 or section >= N_SECTIONS SHALL be ignored.
REQ-013 clear SHALL zero all history, pipeline valids and sat_flag on the next edge; coefficients SHALL be retained; an in_valid coincident with clear SHALL be dropped.
REQ-014 When out_valid is low, y SHALL hold its last value.

Reset
REQ-015 rst low SHALL asynchronously set y=0, out_valid=0, sat_flag=0, all history 0.
REQ-016 Reset SHALL load every section with b0 = 1<<FRAC_BITS, b1=b2=a1=a2=0 (passthrough).
REQ-017 Reset mid-stream SHALL discard all in-flight samples; no out_valid until a new in_valid has propagated.

Configuration
REQ-018 With IIR_SAT_EN defined, each section output SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set sat_flag on clamp.
REQ-019 Without IIR_SAT_EN, section output SHALL be the low DATA_W bits (two's-complement wrap) and sat_flag SHALL be tied 0.

Structure
REQ-020 Package iir_pkg SHALL hold coefficient index constants (B0..A2), default widths and the passthrough-b0 function.
REQ-021 One sub-module iir_biquad_section SHALL implement a single section (history, MAC, round/saturate, output register); the top SHALL generate N_SECTIONS instances and the coefficient register file.

Verification (defaults N_SECTIONS=2, DATA_W=32, COEF_W=16, FRAC_BITS=14)
REQ-022 After reset, x=1000 with in_valid -> y=1000, out_valid 2 cycles later.
REQ-023 Write b0=8192 to both sections, x=1000 -> y=250.
REQ-024 Section 0: b0=16384, a1=-8192; section 1 passthrough; impulse x=1024 then zeros -> y=1024,512,256,128 on consecutive valid outputs; bubbles between inputs leave sequence unchanged.
REQ-025 b0=32767 on section 0, x=2^31-1 -> IIR_SAT_EN: y=2^31-1, sat_flag=1; without: y equals wrapped value, sat_flag=0.
REQ-026 Assert rst low, or clear, during REQ-024 impulse tail -> out_valid=0, y=0 (rst) and next impulse reproduces 1024,512,... from zero history.
